// File: rtl/vedic_mul_seq_ctrl_pkg.sv
// Shared types for the sequential vedic multiplier.
// States and digit/partial-product widths.
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DIGIT_W = 2;
  localparam int PP_W    = 4;

endpackage

// File: rtl/vedic_mul_seq_ctrl_if.sv
// Operand/result valid-ready bundle.
// master = producer/consumer side, slave = multiplier side.
interface vedic_mul_seq_ctrl_if #(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product
  );

endinterface

// File: rtl/vedic_mul_seq_ctrl_vedic_2x2.sv
// Combinational 2x2 vedic (urdhva) multiplier.
// Vertical/crosswise digit products with a single carry.
module vedic_2x2
  import vedic_pkg::*;
(
  input  logic [DIGIT_W-1:0] mul_1,
  input  logic [DIGIT_W-1:0] mul_2,
  output logic [PP_W-1:0]    product
);

  logic cross_a;
  logic cross_b;
  logic carry;
  logic top;

  assign cross_a = mul_1[1] & mul_2[0];
  assign cross_b = mul_1[0] & mul_2[1];
  assign carry   = cross_a & cross_b;
  assign top     = mul_1[1] & mul_2[1];

  assign product[0] = mul_1[0] & mul_2[0];
  assign product[1] = cross_a ^ cross_b;
  assign product[2] = top ^ carry;
  assign product[3] = top & carry;

endmodule

// File: rtl/vedic_mul_seq_ctrl.sv
// Digit-serial WIDTH x WIDTH multiplier around one vedic_2x2.
// VEDIC_SEQ_ZERO_SKIP_EN: zero operands finish in one cycle.
module vedic_mul_seq_ctrl
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vedic_mul_seq_ctrl_if.slave  bus,
  output logic                 busy
);

  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * WIDTH;

  localparam logic [IW-1:0] IMAX = IW'(D - 1);

  state_t state_q, state_n;

  logic [IW-1:0]    i_q, i_n;
  logic [IW-1:0]    j_q, j_n;
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [PW-1:0]    acc_q, acc_n;
  logic [PW-1:0]    prod_q, prod_n;
  logic             ov_q, ov_n;

  logic [DIGIT_W-1:0] da;
  logic [DIGIT_W-1:0] db;
  logic [PP_W-1:0]    pp4;
  logic [IW:0]        dsum;
  logic [PW-1:0]      pp_sh;
  logic [PW-1:0]      acc_sum;
  logic               last;
  logic               take;
  logic               give;
  logic               zero_op;

  assign da = a_q[DIGIT_W*i_q +: DIGIT_W];
  assign db = b_q[DIGIT_W*j_q +: DIGIT_W];

  vedic_2x2 u_mul (
    .mul_1   (da),
    .mul_2   (db),
    .product (pp4)
  );

  assign dsum    = {1'b0, i_q} + {1'b0, j_q};
  assign pp_sh   = PW'(pp4) << {dsum, 1'b0};
  assign acc_sum = acc_q + pp_sh;
  assign last    = (i_q == IMAX) && (j_q == IMAX);
  assign take    = bus.in_valid && (state_q == IDLE);
  assign give    = bus.out_ready && ov_q;

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    state_n = state_q;
    i_n     = i_q;
    j_n     = j_q;
    a_n     = a_q;
    b_n     = b_q;
    acc_n   = acc_q;
    prod_n  = prod_q;
    ov_n    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          a_n   = bus.a;
          b_n   = bus.b;
          acc_n = '0;
          i_n   = '0;
          j_n   = '0;
          if (zero_op) begin
            prod_n  = '0;
            ov_n    = 1'b1;
            state_n = DONE;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        acc_n = acc_sum;
        if (last) begin
          prod_n  = acc_sum;
          ov_n    = 1'b1;
          i_n     = '0;
          j_n     = '0;
          state_n = DONE;
        end else if (j_q == IMAX) begin
          j_n = '0;
          i_n = i_q + 1'b1;
        end else begin
          j_n = j_q + 1'b1;
        end
      end
      DONE: begin
        if (give) begin
          ov_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      i_q     <= i_n;
      j_q     <= j_n;
      a_q     <= a_n;
      b_q     <= b_n;
      acc_q   <= acc_n;
      prod_q  <= prod_n;
      ov_q    <= ov_n;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.product   = prod_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Bench for vedic_mul_seq_ctrl at WIDTH=8 and WIDTH=4.
// Reference: plain a*b, latency D*D (1 for zero operands when skip is on).
`timescale 1ns/1ps
module tb_vedic_mul_seq_ctrl;

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic busy8;
  logic busy4;

  always #5 clk = ~clk;

  vedic_mul_seq_ctrl_if #(.WIDTH(8)) bus8 ();
  vedic_mul_seq_ctrl_if #(.WIDTH(4)) bus4 ();

  vedic_mul_seq_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8),
    .busy  (busy8)
  );

  vedic_mul_seq_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4),
    .busy  (busy4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d, input bit zero);
    return (ZS && zero) ? 1 : d * d;
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input int hold);
    int lat;
    logic [15:0] expp;
    expp = 16'(a) * 16'(b);
    @(negedge clk);
    check("in_ready_pre8", bus8.in_ready, 1);
    bus8.in_valid  = 1'b1;
    bus8.a         = a;
    bus8.b         = b;
    bus8.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.a        = 8'($urandom);
    bus8.b        = 8'($urandom);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus8.out_valid) break;
      check("in_ready_run8", bus8.in_ready, 0);
    end
    check("latency8", lat, lat_of(4, (a == 0) || (b == 0)));
    check("product8", bus8.product, expp);
    check("busy_done8", busy8, 1);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", bus8.out_valid, 1);
      check("hold_prod", bus8.product, expp);
      check("hold_ready", bus8.in_ready, 0);
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("ov_drop8", bus8.out_valid, 0);
    check("in_ready_post8", bus8.in_ready, 1);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    int lat;
    logic [7:0] expp;
    expp = 8'(a) * 8'(b);
    @(negedge clk);
    bus4.in_valid  = 1'b1;
    bus4.a         = a;
    bus4.b         = b;
    bus4.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus4.out_valid) break;
    end
    check("latency4", lat, lat_of(2, (a == 0) || (b == 0)));
    check("product4", bus4.product, expp);
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
    check("in_ready_post4", bus4.in_ready, 1);
  endtask

  task automatic random_run(input int n);
    logic [15:0] q[$];
    logic [15:0] expp;
    int got_n;
    int cyc;
    bit acc_now;
    bit out_now;
    got_n = 0;
    cyc = 0;
    @(negedge clk);
    bus8.in_valid  = 1'b1;
    bus8.a         = 8'($urandom);
    bus8.b         = 8'($urandom);
    bus8.out_ready = 1'($urandom_range(0, 1));
    while (got_n < n && cyc < 60000) begin
      cyc++;
      acc_now = bus8.in_valid && bus8.in_ready;
      out_now = bus8.out_valid && bus8.out_ready;
      if (out_now) begin
        if (q.size() == 0) begin
          check("rand_spurious", 1, 0);
        end else begin
          expp = q.pop_front();
          check("rand_prod", bus8.product, expp);
        end
        got_n++;
      end
      if (acc_now) q.push_back(16'(bus8.a) * 16'(bus8.b));
      @(posedge clk);
      #1;
      if (acc_now) begin
        bus8.a = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
        bus8.b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      end
      bus8.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    check("rand_count", got_n, n);
    repeat (20) @(negedge clk);
    bus8.out_ready = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.out_ready = 1'b0;
    #12;
    check("rst_in_ready", bus8.in_ready, 1);
    check("rst_busy", busy8, 0);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_product", bus8.product, 0);
    check("rst_busy4", busy4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'd3, 8'd5, 0);
    op8(8'd255, 8'd255, 0);
    op8(8'd170, 8'd85, 0);
    op8(8'd0, 8'd7, 0);
    op8(8'd9, 8'd0, 0);
    op8(8'd200, 8'd199, 5);

    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.a        = 8'd3;
    bus8.b        = 8'd7;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ov", bus8.out_valid, 0);
    check("midrst_busy", busy8, 0);
    check("midrst_ready", bus8.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'd12, 8'd12, 0);

    op4(4'd15, 4'd15);
    op4(4'd3, 4'd5);
    op4(4'd0, 4'd3);

    random_run(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
